pipe_perf_monitor: RTL

Synthesizable, parametrised event counter for the pipelined CPU, replacing bench-side stall/flush bookkeeping with hardware counters. It counts run cycles plus `NUM_EV` per-cycle event strobes (stall, flush, retire, user), stops itself after a programmable cycle budget, and supports snapshot capture and indexed readback. It sits beside the CPU top level; hazard-detection and flush signals feed `event_i`.

---
 rtl/pipe_perf_monitor_if.sv | 29 ++
 rtl/pipe_perf_monitor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_perf_monitor_if.sv
// Bundle of control, event and readback signals between the CPU-side
// controller (master) and the performance monitor (slave).
interface pipe_perf_monitor_if #(
    parameter int CNT_WIDTH = 32,
    parameter int NUM_EV    = 4,
    parameter int SEL_W     = $clog2(NUM_EV + 1)
);
    logic                  start_i;
    logic [NUM_EV-1:0]     event_i;
    logic                  clear_i;
    logic                  snap_i;
    logic [SEL_W-1:0]      sel_i;
    logic [CNT_WIDTH-1:0]  live_o;
    logic [CNT_WIDTH-1:0]  snap_o;
    logic [NUM_EV:0]       ovf_o;
    logic [1:0]            state_o;
    logic                  done_o;
    logic                  snap_valid_o;

    modport master (
        output start_i, event_i, clear_i, snap_i, sel_i,
        input  live_o, snap_o, ovf_o, state_o, done_o, snap_valid_o
    );

    modport slave (
        input  start_i, event_i, clear_i, snap_i, sel_i,
        output live_o, snap_o, ovf_o, state_o, done_o, snap_valid_o
    );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: a run-cycle counter plus one saturating
// counter per event strobe, a cycle budget that parks the block in DONE,
// a snapshot bank and indexed readback. Counter slot 0 is the cycle
// counter, slot k+1 counts event k.
module pipe_perf_monitor #(
    parameter int CNT_WIDTH  = 32,
    parameter int NUM_EV     = 4,
    parameter int MAX_CYCLES = 30,
    parameter int SEL_W      = $clog2(NUM_EV + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_perf_monitor_if.slave bus
);

    localparam int                   NUM_CNT   = NUM_EV + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH:0]   EXT_ONE   = (CNT_WIDTH+1)'(1'b1);
    // Widened by one bit so a budget larger than the counter range never matches.
    localparam logic [CNT_WIDTH:0]   BUDGET    = (CNT_WIDTH+1)'(MAX_CYCLES);
    localparam logic                 BUDGET_EN = (MAX_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q  [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d  [NUM_CNT];
    logic [CNT_WIDTH-1:0] snap_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] snap_d [NUM_CNT];
    logic [NUM_CNT-1:0]   ovf_q, ovf_d;
    logic                 snap_valid_q, snap_valid_d;
    logic [NUM_CNT-1:0]   inc_s;
    logic                 count_en_s;
    logic                 budget_hit_s;
    logic [CNT_WIDTH-1:0] live_s;
    logic [CNT_WIDTH-1:0] snap_rd_s;

    // Per-slot increment requests and the budget-completion condition.
    always_comb begin
        inc_s        = {bus.event_i, 1'b1};
        count_en_s   = (state_q == ST_RUN) && bus.start_i;
        budget_hit_s = 1'b0;
        if (BUDGET_EN && count_en_s && !bus.clear_i &&
            (({1'b0, cnt_q[0]} + EXT_ONE) == BUDGET)) begin
            budget_hit_s = 1'b1;
        end else begin
            budget_hit_s = 1'b0;
        end
    end

    // Next-state logic: start_i gates RUN, the budget parks in DONE until clear.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) state_d = ST_RUN;
                else             state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (!bus.start_i)     state_d = ST_IDLE;
                else if (budget_hit_s) state_d = ST_DONE;
                else                  state_d = ST_RUN;
            end
            ST_DONE: begin
                if (bus.clear_i) state_d = ST_IDLE;
                else             state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Live counter update: clear wins over counting; saturate and flag instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (bus.clear_i) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_d[i] = CNT_ZERO;
            end
            ovf_d = {NUM_CNT{1'b0}};
        end else if (count_en_s) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (inc_s[i] && (cnt_q[i] == CNT_MAX)) begin
                    ovf_d[i] = 1'b1;
                end else if (inc_s[i]) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Snapshot bank takes the pre-edge live values, independent of clear/count.
    always_comb begin
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        if (bus.snap_i) begin
            snap_d       = cnt_q;
            snap_valid_d = 1'b1;
        end else begin
            snap_valid_d = snap_valid_q;
        end
    end

    // State, counters, flags and snapshots; reset discards everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ovf_q        <= {NUM_CNT{1'b0}};
            snap_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i]  <= CNT_ZERO;
                snap_q[i] <= CNT_ZERO;
            end
        end else begin
            state_q      <= state_d;
            ovf_q        <= ovf_d;
            snap_valid_q <= snap_valid_d;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i]  <= cnt_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    // Indexed readback; indices beyond the last event read as zero.
    always_comb begin
        live_s    = CNT_ZERO;
        snap_rd_s = CNT_ZERO;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (bus.sel_i == SEL_W'(i)) begin
                live_s    = cnt_q[i];
                snap_rd_s = snap_q[i];
            end else begin
                live_s    = live_s;
                snap_rd_s = snap_rd_s;
            end
        end
    end

    assign bus.live_o       = live_s;
    assign bus.snap_o       = snap_rd_s;
    assign bus.ovf_o        = ovf_q;
    assign bus.state_o      = state_q;
    assign bus.done_o       = (state_q == ST_DONE);
    assign bus.snap_valid_o = snap_valid_q;

endmodule
